// File: rtl/score_recorder.sv
// Purpose: records keypad notes as (note, octave, length_ms) entries into a score RAM; SCORE_REC_REST_EN adds rest entries.
// Latency: an entry is written one clk after the event that closes it; the end marker follows the flush by one clk.
// Backpressure: none; the RAM takes a write every cycle, and when it is full presses are ignored until en drops.
module score_recorder #(
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_1ms,
  input  logic              en,
  input  logic              key_down,
  input  logic [3:0]        note,
  input  logic [3:0]        octave,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_note,
  output logic [3:0]        wr_octave,
  output logic [15:0]       wr_length,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              recording
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    NOTE,
`ifdef SCORE_REC_REST_EN
    GAP,
`endif
    STOP,
    FULL
  } state_t;

  state_t              state_q, state_d;
  logic                clk_1ms_q;
  logic [3:0]          cur_note_q, cur_note_d;
  logic [3:0]          cur_oct_q, cur_oct_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     count_d;
  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [3:0]          wr_note_d, wr_octave_d;
  logic [15:0]         wr_length_d;

  logic                tick;
  logic [15:0]         len_inc;
  logic                pair_changed;
  logic                wr_req;
  logic [3:0]          req_note, req_oct;
  logic [15:0]         req_len;

  assign tick         = clk_1ms & ~clk_1ms_q;
  assign len_inc      = (len_q == MAX_LEN) ? len_q : len_q + 16'd1;
  assign pair_changed = ({note, octave} != {cur_note_q, cur_oct_q});
  assign full         = (count == DEPTH);
  assign recording    = (state_q != IDLE);

  // State register plus tick edge detector, latched pair, length counter and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_1ms_q  <= 1'b0;
      cur_note_q <= 4'd0;
      cur_oct_q  <= 4'd0;
      len_q      <= 16'd0;
      count      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_note    <= 4'd0;
      wr_octave  <= 4'd0;
      wr_length  <= 16'd0;
    end else begin
      state_q    <= state_d;
      clk_1ms_q  <= clk_1ms;
      cur_note_q <= cur_note_d;
      cur_oct_q  <= cur_oct_d;
      len_q      <= len_d;
      count      <= count_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_note    <= wr_note_d;
      wr_octave  <= wr_octave_d;
      wr_length  <= wr_length_d;
    end
  end

  // Next state; closing events raise wr_req, and a tick coinciding with a close is dropped because
  // the closing branch wins over the tick branch.
  always_comb begin
    state_d    = state_q;
    cur_note_d = cur_note_q;
    cur_oct_d  = cur_oct_q;
    len_d      = len_q;
    count_d    = count;
    wr_req     = 1'b0;
    req_note   = cur_note_q;
    req_oct    = cur_oct_q;
    req_len    = len_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          count_d = '0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!en) begin
          state_d = STOP;
        end else if (key_down) begin
          cur_note_d = note;
          cur_oct_d  = octave;
          len_d      = 16'd0;
          state_d    = NOTE;
        end
      end
      NOTE: begin
        if (!en) begin
          wr_req  = (len_q != 16'd0);
          state_d = STOP;
        end else if (!key_down) begin
          wr_req = (len_q != 16'd0);
          len_d  = 16'd0;
`ifdef SCORE_REC_REST_EN
          state_d = GAP;
`else
          state_d = ARMED;
`endif
        end else if (pair_changed) begin
          wr_req     = (len_q != 16'd0);
          cur_note_d = note;
          cur_oct_d  = octave;
          len_d      = 16'd0;
        end else if (tick) begin
          len_d = len_inc;
        end
      end
`ifdef SCORE_REC_REST_EN
      GAP: begin
        // A rest still open when recording stops is simply dropped.
        if (!en) begin
          state_d = STOP;
        end else if (key_down) begin
          wr_req     = (len_q != 16'd0);
          req_note   = 4'd0;
          req_oct    = 4'd0;
          cur_note_d = note;
          cur_oct_d  = octave;
          len_d      = 16'd0;
          state_d    = NOTE;
        end else if (tick) begin
          len_d = len_inc;
        end
      end
`endif
      STOP: begin
        if (count != DEPTH) begin
          wr_req   = 1'b1;
          req_note = 4'd0;
          req_oct  = 4'd0;
          req_len  = 16'd0;
        end
        state_d = IDLE;
      end
      FULL: begin
        if (!en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_en_d     = wr_req;
    wr_addr_d   = wr_addr;
    wr_note_d   = wr_note;
    wr_octave_d = wr_octave;
    wr_length_d = wr_length;
    if (wr_req) begin
      wr_addr_d   = count[ADDR_W-1:0];
      wr_note_d   = req_note;
      wr_octave_d = req_oct;
      wr_length_d = req_len;
      count_d     = count + 1'b1;
      // A write taking the last slot during recording parks in FULL; stop-time writes just finish.
      if (state_q != STOP && state_d != STOP && count_d == DEPTH) begin
        state_d = FULL;
      end
    end
  end

endmodule

// File: tb/tb_score_recorder.sv
module tb_score_recorder;

  localparam int AW    = 3;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int MAXL  = 600;
  localparam int EW    = AW + 8 + 16 + CW;
`ifdef SCORE_REC_REST_EN
  localparam bit REST = 1'b1;
`else
  localparam bit REST = 1'b0;
`endif

  typedef logic [EW-1:0] entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clk_1ms = 1'b0;
  logic          en = 1'b0;
  logic          key_down = 1'b0;
  logic [3:0]    note = 4'd0;
  logic [3:0]    octave = 4'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_note;
  logic [3:0]    wr_octave;
  logic [15:0]   wr_length;
  logic [CW-1:0] count;
  logic          full;
  logic          recording;

  int checks = 0;
  int failures = 0;

  // Segment model: what the player did since recording started.
  bit         kind_q[$];   // 1 = key held, 0 = silence
  logic [7:0] pair_q[$];
  int         tick_q[$];
  bit         held = 1'b0;
  logic [7:0] cur_pair = 8'h00;

  entry_t act_q[$];
  entry_t exp_q[$];

  score_recorder #(.ADDR_W(AW), .MAX_LEN(16'(MAXL))) dut (
    .clk(clk), .rst_n(rst_n), .clk_1ms(clk_1ms), .en(en), .key_down(key_down),
    .note(note), .octave(octave), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
    .wr_octave(wr_octave), .wr_length(wr_length), .count(count), .full(full),
    .recording(recording)
  );

  always #5 clk = ~clk;

  // Capture every RAM write together with the count visible during the strobe.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1)
      act_q.push_back({wr_addr, wr_note, wr_octave, wr_length, count});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] kn, input logic [3:0] ko);
    note = kn; octave = ko; key_down = 1'b1; held = 1'b1; cur_pair = {kn, ko};
    kind_q.push_back(1'b1); pair_q.push_back({kn, ko}); tick_q.push_back(0);
    step();
  endtask

  task automatic rel();
    key_down = 1'b0; held = 1'b0;
    kind_q.push_back(1'b0); pair_q.push_back(8'h00); tick_q.push_back(0);
    step();
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      clk_1ms = 1'b1; step();
      clk_1ms = 1'b0; step();
      if (tick_q.size() > 0) tick_q[tick_q.size()-1] += 1;
    end
  endtask

  task automatic start_rec();
    kind_q.delete(); pair_q.delete(); tick_q.delete(); act_q.delete();
    en = 1'b1; step(); step();
  endtask

  task automatic stop_rec();
    en = 1'b0; repeat (4) step();
    key_down = 1'b0; held = 1'b0; step();
  endtask

  // Expected RAM contents from the segment list: non-empty notes, interior non-empty rests
  // (when rests are built in), lengths saturated, capacity respected, marker if a slot is left.
  task automatic build_exp();
    int cnt = 0;
    int len;
    exp_q.delete();
    for (int i = 0; i < kind_q.size(); i++) begin
      if (cnt == DEPTH) break;
      len = (tick_q[i] > MAXL) ? MAXL : tick_q[i];
      if (len == 0) continue;
      if (kind_q[i]) begin
        exp_q.push_back({AW'(cnt), pair_q[i], 16'(len), CW'(cnt + 1)});
        cnt++;
      end else if (REST && i != kind_q.size() - 1) begin
        exp_q.push_back({AW'(cnt), 8'h00, 16'(len), CW'(cnt + 1)});
        cnt++;
      end
    end
    if (cnt < DEPTH) exp_q.push_back({AW'(cnt), 8'h00, 16'h0000, CW'(cnt + 1)});
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_note, wr_octave, wr_length, count, full, recording} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {wr_en, wr_addr, wr_note, wr_octave, wr_length, count, full, recording});
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if ({wr_en, count, recording} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h required 0", {wr_en, count, recording});
    end
  endtask

  task automatic test_single_note();
    start_rec();
    key(4'd5, 4'd4);
    ticks(300);
    key_down = 1'b0; held = 1'b0;
    kind_q.push_back(1'b0); pair_q.push_back(8'h00); tick_q.push_back(0);
    @(posedge clk); #1;
    checks++;
    if ({wr_en, wr_addr, wr_note, wr_octave, wr_length, count} !== {1'b1, 3'd0, 4'd5, 4'd4, 16'd300, 4'd1}) begin
      failures++;
      $display("FAIL release_write: got en=%b addr=%0d note=%0d oct=%0d len=%0d count=%0d required 1,0,5,4,300,1",
               wr_en, wr_addr, wr_note, wr_octave, wr_length, count);
    end
    @(posedge clk); #1;
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL strobe_one_cycle: got wr_en=%b required 0", wr_en);
    end
    step();
    stop_rec();
    checks++;
    if (recording !== 1'b0) begin
      failures++;
      $display("FAIL recording_after_stop: got %b required 0", recording);
    end
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_note_writes: got %0d required %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL single_note_entry%0d: got %h required %h", i, act_q[i], exp_q[i]);
      end
    end

    // Press and release inside one tick period: nothing but the marker.
    start_rec();
    key(4'd9, 4'd1);
    rel();
    step();
    checks++;
    if (count !== 4'd0 || act_q.size() != 0) begin
      failures++;
      $display("FAIL short_press: got count=%0d writes=%0d required 0,0", count, act_q.size());
    end
    stop_rec();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size() || (act_q.size() > 0 && act_q[0] !== exp_q[0])) begin
      failures++;
      $display("FAIL short_press_marker: got %0d writes required %0d", act_q.size(), exp_q.size());
    end
  endtask

  task automatic test_rests();
    start_rec();
    key(4'd1, 4'd4); ticks(100);
    rel();           ticks(50);
    key(4'd3, 4'd4); ticks(20);
    stop_rec();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size() || count !== CW'(exp_q.size())) begin
      failures++;
      $display("FAIL rest_seq_writes: got %0d count=%0d required %0d", act_q.size(), count, exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rest_seq_entry%0d: got %h required %h", i, act_q[i], exp_q[i]);
      end
    end

    // Ticks that land on a release or a press count in neither neighbouring entry.
    start_rec();
    key(4'd1, 4'd1); ticks(3);
    clk_1ms = 1'b1; key_down = 1'b0; held = 1'b0;
    kind_q.push_back(1'b0); pair_q.push_back(8'h00); tick_q.push_back(0);
    step(); clk_1ms = 1'b0; step();
    ticks(2);
    clk_1ms = 1'b1; key(4'd2, 4'd2); clk_1ms = 1'b0; step();
    ticks(4);
    stop_rec();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL coincident_writes: got %0d required %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL coincident_entry%0d: got %h required %h", i, act_q[i], exp_q[i]);
      end
    end

    // Key change in the same cycle en falls: the stop wins, the old note is flushed.
    start_rec();
    key(4'd4, 4'd4); ticks(5);
    en = 1'b0; note = 4'd6; octave = 4'd6;
    repeat (4) step();
    key_down = 1'b0; held = 1'b0; step();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stop_priority_writes: got %0d required %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stop_priority_entry%0d: got %h required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    start_rec();
    key(4'd7, 4'd3); ticks(700); rel();
    stop_rec();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size() || (act_q.size() > 0 && act_q[0] !== exp_q[0])) begin
      failures++;
      $display("FAIL saturation: got %0d writes first=%h required %0d first=%h",
               act_q.size(), (act_q.size() > 0) ? act_q[0] : entry_t'(0), exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_full();
    start_rec();
    for (int i = 0; i < DEPTH; i++) begin
      key(4'(i + 1), 4'd2); ticks(2); rel();
    end
    step();
    checks++;
    if (full !== 1'b1 || count !== CW'(DEPTH) || recording !== 1'b1) begin
      failures++;
      $display("FAIL full_flag: got full=%b count=%0d rec=%b required 1,%0d,1", full, count, recording, DEPTH);
    end
    key(4'd9, 4'd9); ticks(3); rel(); step();
    checks++;
    if (act_q.size() != DEPTH) begin
      failures++;
      $display("FAIL press_when_full: got %0d writes required %0d", act_q.size(), DEPTH);
    end
    stop_rec();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL full_no_marker: got %0d writes required %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL full_entry%0d: got %h required %h", i, act_q[i], exp_q[i]);
      end
    end
    checks++;
    if (full !== 1'b1 || recording !== 1'b0) begin
      failures++;
      $display("FAIL full_held_idle: got full=%b rec=%b required 1,0", full, recording);
    end
    start_rec();
    checks++;
    if (full !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL full_cleared: got full=%b count=%0d required 0,0", full, count);
    end
    stop_rec();
  endtask

  task automatic test_reset_mid_note();
    start_rec();
    key(4'd2, 4'd5); ticks(10); rel();
    key(4'd3, 4'd6); ticks(40);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_note, wr_octave, wr_length, count, full, recording} !== '0) begin
      failures++;
      $display("FAIL reset_mid_note: got %h required 0",
               {wr_en, wr_addr, wr_note, wr_octave, wr_length, count, full, recording});
    end
    en = 1'b0; key_down = 1'b0; held = 1'b0;
    step();
    act_q.delete();
    rst_n = 1'b1;
    key(4'd1, 4'd1); ticks(3); rel(); ticks(2); step();
    checks++;
    if (act_q.size() != 0 || recording !== 1'b0) begin
      failures++;
      $display("FAIL no_write_after_reset: got writes=%0d rec=%b required 0,0", act_q.size(), recording);
    end
    start_rec();
    key(4'd6, 4'd1); ticks(7); rel();
    stop_rec();
    build_exp();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rerecord_writes: got %0d required %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rerecord_entry%0d: got %h required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] rn, ro;
    for (int r = 0; r < 10; r++) begin
      start_rec();
      repeat ($urandom_range(1, 12)) begin
        if (held && $urandom_range(0, 2) == 0) begin
          rel();
        end else begin
          rn = 4'($urandom_range(0, 15));
          ro = 4'($urandom_range(0, 15));
          if (held && {rn, ro} == cur_pair) rn = rn + 4'd1;
          key(rn, ro);
        end
        ticks($urandom_range(0, 4));
      end
      stop_rec();
      build_exp();
      checks++;
      if (act_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL random%0d_writes: got %0d required %0d", r, act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random%0d_entry%0d: got %h required %h", r, i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rests();
    test_saturation();
    test_full();
    test_reset_mid_note();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
